// File: rtl/ccc_seq_pkg.sv
// rtl/ccc_seq_pkg.sv - shared state encoding and helpers for the CCC reset sequencer
//
// Purpose : state encoding visible on the debug STATE output, plus a
//           constant-evaluable clog2 used to size the stage index.
// Ports   : none (package).
package ccc_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// rtl/ccc_lock_sync.sv - generic two-flop synchroniser for asynchronous status inputs
//
// Purpose : brings an asynchronous level into the i_clk domain; outputs 0
//           while reset is asserted.
// Ports   : i_clk   - destination clock
//           i_rst_n - asynchronous active-low reset
//           i_async - asynchronous input level(s)
//           o_sync  - synchronised level(s), two edges of latency
module ccc_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ccc_lock_reset_sequencer.sv
// rtl/ccc_lock_reset_sequencer.sv - CCC lock qualified, staged fabric reset release
//
// Purpose : waits for a stable CCC lock (or BYPASS), then releases the
//           fabric reset domains one by one with a fixed gap. Lock loss or a
//           software re-sequence request puts every domain back into reset.
// Ports   : i_fab_clk     - fabric clock
//           i_m2f_reset_n - asynchronous active-low reset
//           i_lock_in     - CCC lock, asynchronous
//           i_bypass      - quasi-static, lock treated as always present
//           i_reseq_req   - four-phase re-sequence request
//           o_reseq_ack   - four-phase acknowledge
//           o_rst_n_out   - per-domain active-low resets, bit 0 first
//           o_ready       - all domains released
//           o_timeout     - sticky, lock not stable in time
//           o_loss_cnt    - saturating lock-loss count
//           o_state       - debug state encoding
module ccc_lock_reset_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int NUM_STAGES         = 3,
  parameter int TIMEOUT_CYCLES     = 65535,
  parameter int CNT_W              = 16,
  parameter int LOSS_W             = 8
) (
  input  logic                  i_fab_clk,
  input  logic                  i_m2f_reset_n,
  input  logic                  i_lock_in,
  input  logic                  i_bypass,
  input  logic                  i_reseq_req,
  output logic                  o_reseq_ack,
  output logic [NUM_STAGES-1:0] o_rst_n_out,
  output logic                  o_ready,
  output logic                  o_timeout,
  output logic [LOSS_W-1:0]     o_loss_cnt,
  output logic [1:0]            o_state
);

  localparam int STG_W = clog2(NUM_STAGES) + 1;

  logic                  w_lock_s;
  logic                  w_lk;

  state_t                r_state,   w_state_nxt;
  logic [NUM_STAGES-1:0] r_rst_n,   w_rst_n_nxt;
  logic                  r_ready,   w_ready_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic [LOSS_W-1:0]     r_loss,    w_loss_nxt;
  logic                  r_ack,     w_ack_nxt;
  logic [CNT_W-1:0]      r_stab,    w_stab_nxt;
  logic [CNT_W-1:0]      r_to_cnt,  w_to_cnt_nxt;
  logic [CNT_W-1:0]      r_gap,     w_gap_nxt;
  logic [STG_W-1:0]      r_stage,   w_stage_nxt;

  ccc_lock_sync #(.WIDTH(1)) u_lock_sync (
    .i_clk   (i_fab_clk),
    .i_rst_n (i_m2f_reset_n),
    .i_async (i_lock_in),
    .o_sync  (w_lock_s)
  );

  // BYPASS is quasi-static so it skips the synchroniser.
  assign w_lk = w_lock_s | i_bypass;

  always_ff @(posedge i_fab_clk or negedge i_m2f_reset_n) begin
    if (!i_m2f_reset_n) begin
      r_state   <= ST_WAIT_LOCK;
      r_rst_n   <= '0;
      r_ready   <= 1'b0;
      r_timeout <= 1'b0;
      r_loss    <= '0;
      r_ack     <= 1'b0;
      r_stab    <= '0;
      r_to_cnt  <= '0;
      r_gap     <= '0;
      r_stage   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_ready   <= w_ready_nxt;
      r_timeout <= w_timeout_nxt;
      r_loss    <= w_loss_nxt;
      r_ack     <= w_ack_nxt;
      r_stab    <= w_stab_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_gap     <= w_gap_nxt;
      r_stage   <= w_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_n_nxt   = r_rst_n;
    w_ready_nxt   = r_ready;
    w_timeout_nxt = r_timeout;
    w_loss_nxt    = r_loss;
    w_ack_nxt     = r_ack;
    w_stab_nxt    = r_stab;
    w_to_cnt_nxt  = r_to_cnt;
    w_gap_nxt     = r_gap;
    w_stage_nxt   = r_stage;

    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_to_cnt != '1) w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
        // Flag on the edge at which the count reaches TIMEOUT_CYCLES.
        if (r_to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) w_timeout_nxt = 1'b1;
        if (!w_lk) begin
          w_stab_nxt = '0;
        end else if (r_stab == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          w_stab_nxt   = '0;
          w_to_cnt_nxt = '0;
          w_rst_n_nxt  = NUM_STAGES'(1);
          w_gap_nxt    = '0;
          w_stage_nxt  = STG_W'(1);
          if (NUM_STAGES == 1) begin
            w_state_nxt   = ST_RUN;
            w_ready_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end else begin
          w_stab_nxt = r_stab + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!w_lk) begin
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          if (r_loss != '1) w_loss_nxt = r_loss + LOSS_W'(1);
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_gap == CNT_W'(STAGE_GAP - 1)) begin
          // OR-ing one bit per stage keeps the outputs a thermometer code.
          w_rst_n_nxt = r_rst_n | (NUM_STAGES'(1) << r_stage);
          w_gap_nxt   = '0;
          w_stage_nxt = r_stage + STG_W'(1);
          if (r_stage == STG_W'(NUM_STAGES - 1)) begin
            w_state_nxt   = ST_RUN;
            w_ready_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
          end
        end else begin
          w_gap_nxt = r_gap + CNT_W'(1);
        end
      end

      ST_RUN: begin
        // Lock loss wins over a simultaneous request; no ACK is given.
        if (!w_lk) begin
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          if (r_loss != '1) w_loss_nxt = r_loss + LOSS_W'(1);
          w_state_nxt = ST_WAIT_LOCK;
        end else if (i_reseq_req) begin
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!i_reseq_req) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_WAIT_LOCK;
        end
      end

      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  assign o_reseq_ack = r_ack;
  assign o_rst_n_out = r_rst_n;
  assign o_ready     = r_ready;
  assign o_timeout   = r_timeout;
  assign o_loss_cnt  = r_loss;
  assign o_state     = r_state;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// tb/tb_ccc_lock_reset_sequencer.sv - self-checking bench for ccc_lock_reset_sequencer
module tb_ccc_lock_reset_sequencer;

  localparam int LSC  = 8;
  localparam int GAP  = 4;
  localparam int NS   = 3;
  localparam int TO   = 20;
  localparam int LW   = 2;
  localparam int LMAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lock_in;
  logic          bypass;
  logic          req;
  logic          ack;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic          timeout;
  logic [LW-1:0] loss;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ccc_lock_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LSC),
    .STAGE_GAP          (GAP),
    .NUM_STAGES         (NS),
    .TIMEOUT_CYCLES     (TO),
    .CNT_W              (16),
    .LOSS_W             (LW)
  ) dut (
    .i_fab_clk     (clk),
    .i_m2f_reset_n (rst_n),
    .i_lock_in     (lock_in),
    .i_bypass      (bypass),
    .i_reseq_req   (req),
    .o_reseq_ack   (ack),
    .o_rst_n_out   (rst_out),
    .o_ready       (ready),
    .o_timeout     (timeout),
    .o_loss_cnt    (loss),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  // Behavioural model: lock seen through a two-deep delay line, then
  // described as "waiting" (stable streak, time spent), "up" (edges since
  // first release -> number of released domains) or "held".
  bit m_s1, m_s2, m_lk, m_to, m_ack;
  int m_mode;   // 0 waiting, 1 up, 2 held
  int m_streak, m_wait, m_age, m_loss;

  function automatic int n_rel(input int age);
    return (age / GAP + 1 > NS) ? NS : age / GAP + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_s1 = 0; m_s2 = 0; m_mode = 0; m_streak = 0;
      m_wait = 0; m_age = 0; m_loss = 0; m_to = 0; m_ack = 0;
    end else begin
      cyc++;
      m_lk = m_s2 | bypass;
      m_s2 = m_s1;
      m_s1 = lock_in;
      case (m_mode)
        0: begin
          m_wait++;
          if (m_wait >= TO) m_to = 1;
          if (m_lk) begin
            m_streak++;
            if (m_streak == LSC) begin
              m_mode = 1; m_age = 0; m_wait = 0; m_streak = 0;
              if (n_rel(0) == NS) m_to = 0;
            end
          end else m_streak = 0;
        end
        1: begin
          if (!m_lk) begin
            if (m_loss < LMAX) m_loss++;
            m_mode = 0;
          end else if (n_rel(m_age) == NS && req) begin
            m_mode = 2; m_ack = 1;
          end else begin
            m_age++;
            if (n_rel(m_age) == NS) m_to = 0;
          end
        end
        default: begin
          if (!req) begin m_ack = 0; m_mode = 0; end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int er;
      bit erdy;
      int est;
      er   = (m_mode == 1) ? (1 << n_rel(m_age)) - 1 : 0;
      erdy = (m_mode == 1) && (n_rel(m_age) == NS);
      est  = (m_mode == 0) ? 0 : (m_mode == 2) ? 3 : (erdy ? 2 : 1);
      chk("model_rst_n_out", 32'(rst_out), 32'(er));
      chk("model_ready",     32'(ready),   32'(erdy));
      chk("model_timeout",   32'(timeout), 32'(m_to));
      chk("model_loss_cnt",  32'(loss),    32'(m_loss));
      chk("model_reseq_ack", 32'(ack),     32'(m_ack));
      chk("model_state",     32'(state),   32'(est));
    end
  end

  task automatic run_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lk, input logic byp);
    rst_n = 1'b0; lock_in = lk; bypass = byp; req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rst_n_out", 32'(rst_out), 0);
    chk("reset_ready",     32'(ready),   0);
    chk("reset_loss",      32'(loss),    0);
    chk("reset_state",     32'(state),   0);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    int loss_exp[4];
    loss_exp = '{1, 2, 3, 3};

    // Normal bring-up.
    do_reset(1'b1, 1'b0);
    run_to(9);  chk("up_e9",  32'(rst_out), 0);
    run_to(10); chk("up_e10", 32'(rst_out), 1);
    run_to(13); chk("up_e13", 32'(rst_out), 1);
    run_to(14); chk("up_e14", 32'(rst_out), 3);
    run_to(17); chk("up_e17_ready", 32'(ready), 0);
    run_to(18); chk("up_e18", 32'(rst_out), 7);
    chk("up_e18_ready", 32'(ready), 1);
    chk("up_e18_state", 32'(state), 2);

    // Lock loss, four times, saturating count.
    for (int i = 0; i < 4; i++) begin
      b = cyc; lock_in = 1'b0;
      run_to(b + 2); chk("loss_pre",   32'(rst_out), 7);
      run_to(b + 3); chk("loss_rst",   32'(rst_out), 0);
      chk("loss_ready", 32'(ready), 0);
      chk("loss_cnt",   32'(loss),  32'(loss_exp[i]));
      b = cyc; lock_in = 1'b1;
      run_to(b + 18); chk("loss_reup", 32'(rst_out), 7);
    end

    // Re-sequence handshake.
    b = cyc; req = 1'b1;
    run_to(b + 1);
    chk("reseq_rst",   32'(rst_out), 0);
    chk("reseq_ack",   32'(ack),     1);
    chk("reseq_state", 32'(state),   3);
    run_to(b + 3); chk("reseq_hold_ack", 32'(ack), 1);
    req = 1'b0;
    run_to(b + 4);
    chk("reseq_ack_low", 32'(ack),   0);
    chk("reseq_state0",  32'(state), 0);
    run_to(b + 12); chk("reseq_bit0", 32'(rst_out), 1);
    run_to(b + 20); chk("reseq_full", 32'(rst_out), 7);
    chk("reseq_loss", 32'(loss), 3);

    // Glitchy lock.
    do_reset(1'b0, 1'b0);
    run_to(2); lock_in = 1'b1;
    run_to(7); lock_in = 1'b0;
    run_to(8); lock_in = 1'b1;
    run_to(17); chk("glitch_e17", 32'(rst_out), 0);
    run_to(18); chk("glitch_e18", 32'(rst_out), 1);
    chk("glitch_no_to", 32'(timeout), 0);

    // Timeout, then lock loss racing a request.
    do_reset(1'b0, 1'b0);
    run_to(19); chk("to_e19", 32'(timeout), 0);
    run_to(20); chk("to_e20", 32'(timeout), 1);
    run_to(25); lock_in = 1'b1;
    run_to(35); chk("to_bit0", 32'(rst_out), 1);
    run_to(42); chk("to_still", 32'(timeout), 1);
    run_to(43); chk("to_ready", 32'(ready), 1);
    chk("to_clear", 32'(timeout), 0);
    lock_in = 1'b0;
    run_to(45); req = 1'b1;
    run_to(46);
    chk("race_rst",   32'(rst_out), 0);
    chk("race_ack",   32'(ack),     0);
    chk("race_state", 32'(state),   0);
    chk("race_loss",  32'(loss),    1);
    req = 1'b0;

    // Bypass and asynchronous reset mid-release.
    do_reset(1'b0, 1'b1);
    run_to(7);  chk("byp_e7",  32'(rst_out), 0);
    run_to(8);  chk("byp_e8",  32'(rst_out), 1);
    run_to(10); chk("byp_e10", 32'(state),   1);
    rst_n = 1'b0;
    #1;
    chk("arst_rst",   32'(rst_out), 0);
    chk("arst_ready", 32'(ready),   0);
    chk("arst_state", 32'(state),   0);
    chk("arst_loss",  32'(loss),    0);
    @(negedge clk);
    rst_n = 1'b1;
    run_to(8);  chk("byp2_e8",  32'(rst_out), 1);
    run_to(16); chk("byp2_e16", 32'(rst_out), 7);
    chk("byp2_ready", 32'(ready), 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
